// File: rtl/bus_arb_4_if.sv
// Bus between the 4-way arbiter and its requesters.
// The master modport is the arbiter side (drives grants); slave is the requester side.
interface bus_arb_4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;

    modport master (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output tmo
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  tmo
    );
endinterface

// File: rtl/bus_arb_4.sv
// Four-requester round-robin bus arbiter with IDLE/GRANT/RELEASE sequencing and grant timeout.
// Every output comes straight from a register, so req/done never reach an output combinationally.
module bus_arb_4 #(
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    bus_arb_4_if.master  bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sel_q;
    logic [1:0]    lastIdx_q;
    logic          busy_q;
    logic          tmo_q;
    logic [CW-1:0] count_q;

    logic [1:0]    nextOwner;
    logic          found;

    // Search starts just after the previous owner and wraps; first asserted request wins.
    always_comb begin
        nextOwner = lastIdx_q;
        found     = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (!found && bus.req[lastIdx_q + 2'(k)]) begin
                nextOwner = lastIdx_q + 2'(k);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            lastIdx_q <= 2'd3;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q   <= GRANT;
                        gnt_q     <= 4'(1) << nextOwner;
                        sel_q     <= nextOwner;
                        lastIdx_q <= nextOwner;
                        busy_q    <= 1'b1;
                        count_q   <= '0;
                    end
                end
                GRANT: begin
                    // A finished or abandoned transaction releases without flagging a timeout.
                    if (bus.done || !bus.req[sel_q]) begin
                        state_q <= RELEASE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (count_q == COUNT_MAX) begin
                        state_q <= RELEASE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.tmo  = tmo_q;

endmodule

// File: tb/tb_bus_arb_4.sv
// Self-checking bench for bus_arb_4: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of ownership and grant age.
module tb_bus_arb_4;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;
    int   cycle;

    // Model: who owns the bus, how many grant cycles it has had, and the cool-down slot.
    int   modelOwner;
    int   modelHeld;
    bit   modelCool;
    int   modelLast;
    int   modelSel;
    bit   modelTmo;

    bus_arb_4_if busIf ();

    bus_arb_4 #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit r, input logic [3:0] rq, input bit d);
        if (r) begin
            modelOwner = -1;
            modelHeld  = 0;
            modelCool  = 0;
            modelLast  = 3;
            modelSel   = 0;
            modelTmo   = 0;
        end else begin
            modelTmo = 0;
            if (modelCool) begin
                modelCool = 0;
            end else if (modelOwner < 0) begin
                if (rq != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (modelOwner < 0 && rq[(modelLast + k) % 4]) modelOwner = (modelLast + k) % 4;
                    end
                    modelSel  = modelOwner;
                    modelLast = modelOwner;
                    modelHeld = 1;
                end
            end else if (d || !rq[modelOwner]) begin
                modelOwner = -1;
                modelCool  = 1;
            end else if (modelHeld == TIMEOUT) begin
                modelOwner = -1;
                modelCool  = 1;
                modelTmo   = 1;
            end else begin
                modelHeld++;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] rq, input bit d);
        logic [3:0] expGnt;
        rst        = r;
        busIf.req  = rq;
        busIf.done = d;
        @(posedge clk);
        modelStep(r, rq, d);
        cycle++;
        #1;
        expGnt = (modelOwner >= 0) ? (4'b0001 << modelOwner) : 4'b0000;
        checkOutput($sformatf("gnt@%0d", cycle), 32'(busIf.gnt), 32'(expGnt));
        checkOutput($sformatf("sel@%0d", cycle), 32'(busIf.sel), 32'(modelSel));
        checkOutput($sformatf("busy@%0d", cycle), 32'(busIf.busy), 32'(modelOwner >= 0));
        checkOutput($sformatf("tmo@%0d", cycle), 32'(busIf.tmo), 32'(modelTmo));
    endtask

    initial begin
        logic [3:0] rq;
        bit         d;
        bit         r;
        checkCount = 0;
        errorCount = 0;
        cycle      = 0;
        rst        = 1'b1;
        busIf.req  = 4'b0000;
        busIf.done = 1'b0;
        modelStep(1'b1, 4'b0000, 1'b0);

        // Reset state.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("idleGnt", 32'(busIf.gnt), 32'h0);

        // Round robin with all requesting: 0,1,2,3,0.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b1111, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rrGnt%0d", i), 32'(busIf.gnt), 32'(4'b0001 << (i % 4)));
            checkOutput($sformatf("rrSel%0d", i), 32'(busIf.sel), 32'(i % 4));
            if (i < 4) begin
                applyStimulus(0, 4'b1111, 1);
                applyStimulus(0, 4'b1111, 0);
                applyStimulus(0, 4'b1111, 0);
            end
        end

        // Single requester, done, sel retained.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0100, 0);
        checkOutput("singleGnt", 32'(busIf.gnt), 32'h4);
        checkOutput("singleSel", 32'(busIf.sel), 32'd2);
        applyStimulus(0, 4'b0100, 1);
        checkOutput("singleRelGnt", 32'(busIf.gnt), 32'h0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("singleIdleSel", 32'(busIf.sel), 32'd2);

        // Timeout: 4 grant cycles, tmo in RELEASE, re-grant after IDLE.
        applyStimulus(1, 4'b0000, 0);
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(0, 4'b0001, 0);
            checkOutput($sformatf("tmoHeld%0d", i), 32'(busIf.gnt), 32'h1);
        end
        applyStimulus(0, 4'b0001, 0);
        checkOutput("tmoPulse", 32'(busIf.tmo), 32'd1);
        checkOutput("tmoRelGnt", 32'(busIf.gnt), 32'h0);
        applyStimulus(0, 4'b0001, 0);
        checkOutput("tmoPulseEnd", 32'(busIf.tmo), 32'd0);
        applyStimulus(0, 4'b0001, 0);
        checkOutput("tmoRegrant", 32'(busIf.gnt), 32'h1);

        // Done on the cycle the timeout would fire.
        applyStimulus(1, 4'b0000, 0);
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 4'b0001, 0);
        applyStimulus(0, 4'b0001, 1);
        checkOutput("collideGnt", 32'(busIf.gnt), 32'h0);
        checkOutput("collideTmo", 32'(busIf.tmo), 32'd0);

        // Owner drops request.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0010, 0);
        checkOutput("dropOwner", 32'(busIf.gnt), 32'h2);
        applyStimulus(0, 4'b1000, 0);
        checkOutput("dropRel", 32'(busIf.gnt), 32'h0);
        applyStimulus(0, 4'b1000, 0);
        applyStimulus(0, 4'b1000, 0);
        checkOutput("dropNewGnt", 32'(busIf.gnt), 32'h8);
        checkOutput("dropNewSel", 32'(busIf.sel), 32'd3);

        // Reset in the middle of a grant.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0100, 0);
        applyStimulus(0, 4'b0100, 0);
        applyStimulus(1, 4'b1111, 0);
        checkOutput("midRstGnt", 32'(busIf.gnt), 32'h0);
        checkOutput("midRstSel", 32'(busIf.sel), 32'd0);
        checkOutput("midRstTmo", 32'(busIf.tmo), 32'd0);
        applyStimulus(0, 4'b1111, 0);
        checkOutput("midRstFirst", 32'(busIf.gnt), 32'h1);

        // Random traffic with sticky requests so timeouts and drops both occur.
        rq = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 63) == 0);
            applyStimulus(r, rq, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
